// File: rtl/sipo_deser.sv
`default_nettype none
// ============================================================================
// Module  : sipo_deser
// Brief   : Serial-to-parallel deserialiser with frame bit counter, double-
//           buffered valid/ready output and sticky overrun flag.
//           Optional macro SIPO_PARITY_EN appends one even-parity bit per
//           frame and adds the parity_err output.
// Revision: 1.0 - initial release
// ============================================================================
module sipo_deser #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter int CNT_W     = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             shift_en,
  input  logic             data_in,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] bit_count,
  output logic             busy,
`ifdef SIPO_PARITY_EN
  output logic             parity_err,
`endif
  output logic             overrun
);

`ifdef SIPO_PARITY_EN
  localparam logic [CNT_W-1:0] c_LAST_CNT = CNT_W'(WIDTH);
`else
  localparam logic [CNT_W-1:0] c_LAST_CNT = CNT_W'(WIDTH - 1);
`endif

  logic [WIDTH-1:0] r_sreg;
  logic [WIDTH-1:0] w_shifted;
  logic [WIDTH-1:0] w_word;
  logic [WIDTH-1:0] r_data;
  logic [CNT_W-1:0] r_count;
  logic             r_valid;
  logic             r_overrun;
  logic             w_complete;
  logic             w_load;
  logic             w_sreg_en;

  generate
    if (MSB_FIRST) begin : g_msb_first
      assign w_shifted = {r_sreg[WIDTH-2:0], data_in};
    end else begin : g_lsb_first
      assign w_shifted = {data_in, r_sreg[WIDTH-1:1]};
    end
  endgenerate

  assign w_complete = shift_en && (r_count == c_LAST_CNT);
  assign w_load     = w_complete && (!r_valid || out_ready);

`ifdef SIPO_PARITY_EN
  // The parity bit closes the frame but never enters the shift register.
  logic r_parity_err;
  logic w_parity_err;
  assign w_word       = r_sreg;
  assign w_sreg_en    = shift_en && !w_complete;
  assign w_parity_err = (^r_sreg) ^ data_in;
`else
  assign w_word    = w_shifted;
  assign w_sreg_en = shift_en;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sreg  <= '0;
      r_count <= '0;
    end else if (clear) begin
      r_sreg  <= '0;
      r_count <= '0;
    end else begin
      if (w_sreg_en) begin
        r_sreg <= w_shifted;
      end
      if (shift_en) begin
        r_count <= w_complete ? '0 : r_count + CNT_W'(1);
      end
    end
  end

  // Holding register: a completed word is dropped only when the previous one
  // is still unconsumed at the same edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
    end else if (clear) begin
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
    end else if (w_load) begin
      r_data  <= w_word;
      r_valid <= 1'b1;
    end else if (w_complete) begin
      r_overrun <= 1'b1;
    end else if (r_valid && out_ready) begin
      r_valid <= 1'b0;
    end
  end

`ifdef SIPO_PARITY_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_parity_err <= 1'b0;
    end else if (clear) begin
      r_parity_err <= 1'b0;
    end else if (w_load) begin
      r_parity_err <= w_parity_err;
    end
  end

  assign parity_err = r_parity_err;
`endif

  assign out_data  = r_data;
  assign out_valid = r_valid;
  assign bit_count = r_count;
  assign busy      = (r_count != '0);
  assign overrun   = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_sipo_deser.sv
`default_nettype none
// ============================================================================
// Module  : tb_sipo_deser
// Brief   : Scoreboard bench for sipo_deser; one MSB-first and one LSB-first
//           instance share stimulus. Honours SIPO_PARITY_EN when defined.
// Revision: 1.0 - initial release
// ============================================================================
module tb_sipo_deser;
  localparam int WIDTH = 8;
  localparam int CNT_W = $clog2(WIDTH + 1);
`ifdef SIPO_PARITY_EN
  localparam int FRAME = WIDTH + 1;
`else
  localparam int FRAME = WIDTH;
`endif

  typedef struct {
    logic [WIDTH-1:0] m;
    logic [WIDTH-1:0] l;
    logic             p;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic clear = 1'b0;
  logic shift_en = 1'b0;
  logic data_in = 1'b0;
  logic out_ready = 1'b0;

  logic [WIDTH-1:0] data_m, data_l;
  logic             valid_m, valid_l, busy_m, busy_l, ovr_m, ovr_l;
  logic [CNT_W-1:0] cnt_m, cnt_l;
`ifdef SIPO_PARITY_EN
  logic             perr_m, perr_l;
`endif

  int total = 0;
  int bad = 0;

  exp_t       sbq[$];
  bit         bits[$];
  bit         m_valid = 1'b0;
  bit         m_ovr = 1'b0;
  logic [WIDTH-1:0] m_dm = '0;
  logic [WIDTH-1:0] m_dl = '0;
  bit         m_pe = 1'b0;

  sipo_deser #(.WIDTH(WIDTH), .MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .reset_n(reset_n), .clear(clear), .shift_en(shift_en),
    .data_in(data_in), .out_data(data_m), .out_valid(valid_m),
    .out_ready(out_ready), .bit_count(cnt_m), .busy(busy_m),
`ifdef SIPO_PARITY_EN
    .parity_err(perr_m),
`endif
    .overrun(ovr_m)
  );

  sipo_deser #(.WIDTH(WIDTH), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .reset_n(reset_n), .clear(clear), .shift_en(shift_en),
    .data_in(data_in), .out_data(data_l), .out_valid(valid_l),
    .out_ready(out_ready), .bit_count(cnt_l), .busy(busy_l),
`ifdef SIPO_PARITY_EN
    .parity_err(perr_l),
`endif
    .overrun(ovr_l)
  );

  always #5 clk = ~clk;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endfunction

  task automatic model_reset();
    bits.delete();
    sbq.delete();
    m_valid = 1'b0;
    m_ovr   = 1'b0;
    m_dm    = '0;
    m_dl    = '0;
    m_pe    = 1'b0;
  endtask

  // Reference: collect bits into a frame, build words arithmetically on completion.
  task automatic model_step();
    exp_t e;
    bit   complete;
    if (!reset_n || clear) begin
      model_reset();
      return;
    end
    complete = 1'b0;
    if (shift_en) begin
      bits.push_back(data_in);
      complete = (bits.size() == FRAME);
    end
    if (complete) begin
      e.m = '0;
      e.l = '0;
      e.p = 1'b0;
      for (int i = 0; i < WIDTH; i++) begin
        e.m = (e.m << 1) | WIDTH'(bits[i]);
        e.l = e.l | (WIDTH'(bits[i]) << i);
      end
      for (int i = 0; i < FRAME; i++) e.p = e.p ^ bits[i];
      bits.delete();
      if (!m_valid || out_ready) begin
        sbq.push_back(e);
        m_valid = 1'b1;
        m_dm = e.m;
        m_dl = e.l;
        m_pe = e.p;
      end else begin
        m_ovr = 1'b1;
      end
    end else if (m_valid && out_ready) begin
      m_valid = 1'b0;
    end
  endtask

  // Monitor: compares DUT state with the model and pops the scoreboard on each handshake.
  always @(negedge clk) begin
    exp_t e;
    check("valid_m", 64'(valid_m), 64'(m_valid));
    check("valid_l", 64'(valid_l), 64'(m_valid));
    check("overrun_m", 64'(ovr_m), 64'(m_ovr));
    check("overrun_l", 64'(ovr_l), 64'(m_ovr));
    check("bit_count", 64'(cnt_m), 64'(bits.size()));
    check("busy", 64'(busy_m), 64'(bits.size() != 0));
    check("hold_m", 64'(data_m), 64'(m_dm));
    check("hold_l", 64'(data_l), 64'(m_dl));
`ifdef SIPO_PARITY_EN
    check("hold_perr", 64'(perr_m), 64'(m_pe));
`endif
    if (reset_n && !clear && out_ready && valid_m) begin
      if (sbq.size() == 0) begin
        check("sb_unexpected_word", 64'(data_m), 64'hDEAD);
      end else begin
        e = sbq.pop_front();
        check("sb_word_m", 64'(data_m), 64'(e.m));
        check("sb_word_l", 64'(data_l), 64'(e.l));
`ifdef SIPO_PARITY_EN
        check("sb_perr_m", 64'(perr_m), 64'(e.p));
        check("sb_perr_l", 64'(perr_l), 64'(e.p));
`endif
      end
    end
  end

  task automatic drive(input bit se, input bit d, input bit rdy, input bit clr);
    shift_en  = se;
    data_in   = d;
    out_ready = rdy;
    clear     = clr;
    @(negedge clk);
    #1;
    model_step();
    @(posedge clk);
    #2;
  endtask

  task automatic send_word(input logic [WIDTH-1:0] w, input bit rdy, input bit gap, input bit par);
    for (int i = WIDTH - 1; i >= 0; i--) begin
      drive(1'b1, w[i], rdy, 1'b0);
      if (gap) drive(1'b0, 1'b0, rdy, 1'b0);
    end
`ifdef SIPO_PARITY_EN
    drive(1'b1, par, rdy, 1'b0);
    if (gap) drive(1'b0, 1'b0, rdy, 1'b0);
`else
    if (par) drive(1'b0, 1'b0, rdy, 1'b0);
`endif
  endtask

  initial begin
    logic [WIDTH-1:0] w;
    repeat (3) @(posedge clk);
    #2;
    reset_n = 1'b1;
    check("reset_data", 64'(data_m), 64'h0);
    check("reset_valid", 64'(valid_m), 64'h0);

    // MSB-first 0xB2 / LSB-first 0x4D, valid for exactly one cycle
    w = 8'hB2;
    send_word(w, 1'b1, 1'b0, ^w);
    check("b2_msb", 64'(data_m), 64'hB2);
    check("b2_lsb", 64'(data_l), 64'h4D);
    check("b2_valid", 64'(valid_m), 64'h1);
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    check("b2_valid_one_cycle", 64'(valid_m), 64'h0);

    // Overrun then clear
    send_word(w, 1'b0, 1'b0, ^w);
    w = 8'hFF;
    send_word(w, 1'b0, 1'b0, ^w);
    check("ovr_data", 64'(data_m), 64'hB2);
    check("ovr_valid", 64'(valid_m), 64'h1);
    check("ovr_flag", 64'(ovr_m), 64'h1);
    drive(1'b1, 1'b1, 1'b1, 1'b1);
    check("clr_valid", 64'(valid_m), 64'h0);
    check("clr_ovr", 64'(ovr_m), 64'h0);
    check("clr_data", 64'(data_m), 64'h0);
    check("clr_count", 64'(cnt_m), 64'h0);

    // Back-to-back frames, then the same frames with one-cycle gaps
    for (int g = 0; g < 2; g++) begin
      for (int k = 0; k < 3; k++) begin
        w = WIDTH'($urandom);
        send_word(w, 1'b1, g[0], ^w);
      end
      check("b2b_no_overrun", 64'(ovr_m), 64'h0);
    end
    drive(1'b0, 1'b0, 1'b1, 1'b0);

    // Async reset after five bits, then a clean frame
    for (int i = 0; i < 5; i++) drive(1'b1, 1'b1, 1'b1, 1'b0);
    reset_n = 1'b0;
    #1;
    model_reset();
    check("async_rst_count", 64'(cnt_m), 64'h0);
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    reset_n = 1'b1;
    w = 8'hB2;
    send_word(w, 1'b1, 1'b0, ^w);
    check("post_rst_word", 64'(data_m), 64'hB2);
    drive(1'b0, 1'b0, 1'b1, 1'b0);

`ifdef SIPO_PARITY_EN
    send_word(w, 1'b1, 1'b0, 1'b0);
    check("par_ok", 64'(perr_m), 64'h0);
    send_word(w, 1'b1, 1'b0, 1'b1);
    check("par_err", 64'(perr_m), 64'h1);
    check("par_err_data", 64'(data_m), 64'hB2);
    drive(1'b0, 1'b0, 1'b1, 1'b0);
`endif

    // Randomised traffic with back-pressure and occasional clear
    for (int c = 0; c < 600; c++) begin
      drive($urandom_range(0, 3) != 0, 1'($urandom), $urandom_range(0, 3) != 0,
            $urandom_range(0, 99) == 0);
    end

    // Drain: every loaded word must have been consumed
    for (int c = 0; c < 4 && sbq.size() != 0; c++) drive(1'b0, 1'b0, 1'b1, 1'b0);
    check("sb_drained", 64'(sbq.size()), 64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sipo_deser.md
Name: sipo_deser

Overview:
- Parametrised serial-to-parallel deserialiser. Successor to the plain SIPO shift register.
- Adds a selectable shift direction, a frame bit counter and a double-buffered parallel output with a valid/ready handshake.
- Adds overrun detection and a synchronous clear.
- Sits between a serial receive front end and any word-wide consumer.

Parameters:
- WIDTH, 8: data bits per frame; legal range 2..64.
- MSB_FIRST, 1: 1 = first received bit lands in out_data[WIDTH-1]; 0 = first received bit lands in out_data[0].
- CNT_W, $clog2(WIDTH+1): width of bit_count; derived, do not override.

Ports:
- clk, input, 1: rising-edge clock.
- reset_n, input, 1: asynchronous active-low reset.
- clear, input, 1: synchronous clear; has priority over all other inputs except reset_n.
- shift_en, input, 1: sample data_in this cycle.
- data_in, input, 1: serial data bit.
- out_data, output, WIDTH: last completed word (holding register).
- out_valid, output, 1: out_data holds an unconsumed word.
- out_ready, input, 1: consumer accepts out_data when out_valid=1.
- bit_count, output, CNT_W: number of bits collected in the current partial frame.
- busy, output, 1: bit_count != 0.
- overrun, output, 1: sticky; a completed word was dropped.

Behaviour:
- Reset (reset_n=0, asynchronous): shift register=0, bit_count=0, out_data=0, out_valid=0, overrun=0.
- clear=1 at a clock edge: same values as reset, applied synchronously; shift_en and out_ready are ignored that cycle.
- Shift when shift_en=1:
  - MSB_FIRST=1: sreg <= {sreg[WIDTH-2:0], data_in}.
  - MSB_FIRST=0: sreg <= {data_in, sreg[WIDTH-1:1]}.
- bit_count increments on each shift. shift_en=0 holds sreg and bit_count; gaps of any length are legal.
- Frame completion: shift_en=1 with bit_count==WIDTH-1.
  - At that edge, bit_count wraps to 0 and the assembled word, including the current data_in, is offered to the holding register.
  - out_valid is visible one cycle after the last bit is presented (registered at the same edge).
- Holding register update at the completion edge:
  - out_valid=0: load the word; out_valid <= 1.
  - out_valid=1 and out_ready=1: pop and load in the same edge; load the new word, out_valid stays 1, no bubble.
  - out_valid=1 and out_ready=0: drop the new word, out_data unchanged, overrun <= 1.
- No completion and out_valid=1 and out_ready=1: out_valid <= 0; out_data holds its last value.
- out_ready is ignored while out_valid=0.
- overrun clears only on reset_n or clear.
- A back-to-back next frame may start on the cycle after completion; the shift register continues accepting bits regardless of holding-register state.
- Reset or clear mid-frame: the partial word is discarded and no out_valid is produced for it.

Optional Feature:
- Macro: SIPO_PARITY_EN.
- Defined:
  - Each frame is WIDTH data bits followed by one even-parity bit, so frame length is WIDTH+1 and bit_count runs 0..WIDTH.
  - The parity bit is not shifted into sreg.
  - Adds output port parity_err (1 bit), loaded into the holding register alongside out_data. parity_err=1 when XOR of the data bits and the parity bit is 1.
  - parity_err resets/clears to 0 and follows the same drop rule on overrun.
- Not defined: port absent, frame is WIDTH bits, CNT_W unchanged.

Test Plan:
- WIDTH=8, MSB_FIRST=1, out_ready=1: shift bits 1,0,1,1,0,0,1,0 on consecutive cycles -> out_data=8'hB2, out_valid high for exactly 1 cycle; bit_count counts 1..7 then 0.
- WIDTH=8, MSB_FIRST=0, same bit sequence -> out_data=8'h4D.
- out_ready=0: send 0xB2 then 0xFF (MSB first) -> out_data stays 8'hB2, out_valid=1, overrun=1. Then assert clear -> out_valid=0, overrun=0, out_data=0.
- Three back-to-back frames with out_ready=1 asserted on completion cycles -> three words observed with no gap and no overrun. Repeat with shift_en toggling 1,0 every cycle -> same words, completion every 16 cycles.
- Assert reset_n=0 asynchronously after 5 bits, release, then send 0xB2 -> single word 8'hB2; no spurious word from the partial frame.
- With SIPO_PARITY_EN defined:
  - 0xB2 plus parity 0 -> parity_err=0.
  - 0xB2 plus parity 1 -> parity_err=1, out_data=8'hB2.
